// File: rtl/ttt_pkg.sv
// Shared encodings, FSM states, geometry defaults and win-line table for the tic-tac-toe core.
package ttt_pkg;

    localparam int unsigned PIX_W      = 11;
    localparam int unsigned OFS_W      = 7;
    localparam int unsigned BOARD_BITS = 18;
    localparam int unsigned N_CELLS    = 9;
    localparam int unsigned N_LINES    = 8;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    localparam int unsigned DEF_BOARD_X0 = 140;
    localparam int unsigned DEF_BOARD_Y0 = 60;
    localparam int unsigned DEF_CELL     = 120;
    localparam int unsigned DEF_LINE_W   = 4;

    // Cell indices {a,b,c} of win line idx, packed 4 bits each.
    function automatic logic [11:0] win_line(input logic [2:0] idx);
        case (idx)
            3'd0:    return {4'd0, 4'd1, 4'd2};
            3'd1:    return {4'd3, 4'd4, 4'd5};
            3'd2:    return {4'd6, 4'd7, 4'd8};
            3'd3:    return {4'd0, 4'd3, 4'd6};
            3'd4:    return {4'd1, 4'd4, 4'd7};
            3'd5:    return {4'd2, 4'd5, 4'd8};
            3'd6:    return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    function automatic logic [1:0] cell_at(input logic [BOARD_BITS-1:0] b, input logic [3:0] i);
        return b[{i, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational board evaluation: does player own a line (lowest index reported), and is the board full.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [BOARD_BITS-1:0] board,
    input  logic [1:0]            player,
    output logic                  win_c,
    output logic [2:0]            line_c,
    output logic                  full_c
);

    logic [11:0] trip;

    always_comb begin
        win_c  = 1'b0;
        line_c = 3'd0;
        full_c = 1'b1;
        trip   = 12'd0;
        for (int i = 0; i < int'(N_CELLS); i++)
            if (cell_at(board, 4'(i)) == CELL_EMPTY) full_c = 1'b0;
        for (int l = int'(N_LINES) - 1; l >= 0; l--) begin
            trip = win_line(3'(l));
            if (cell_at(board, trip[11:8]) == player &&
                cell_at(board, trip[7:4])  == player &&
                cell_at(board, trip[3:0])  == player) begin
                win_c  = 1'b1;
                line_c = 3'(l);
            end
        end
    end

endmodule

// File: rtl/ttt_pixel_gen.sv
// Tic-tac-toe game FSM plus registered per-pixel colour generator feeding vga_controller.
// Optional build macro TTT_WIN_BLINK_EN blinks the winning line's marks.
module ttt_pixel_gen
    import ttt_pkg::*;
#(
    parameter int unsigned BOARD_X0 = DEF_BOARD_X0,
    parameter int unsigned BOARD_Y0 = DEF_BOARD_Y0,
    parameter int unsigned CELL     = DEF_CELL,
    parameter int unsigned LINE_W   = DEF_LINE_W
)(
    input  logic             clk_25mhz,
    input  logic             clr,
    input  logic [PIX_W-1:0] pixel_x,
    input  logic [PIX_W-1:0] pixel_y,
    input  logic             vga_on,
    input  logic             mv_up,
    input  logic             mv_down,
    input  logic             mv_left,
    input  logic             mv_right,
    input  logic             place,
    input  logic             new_game,
    output logic             ttt_r,
    output logic             ttt_g,
    output logic             ttt_b,
    output logic             turn,
    output logic [1:0]       winner,
    output logic             game_over
);

    localparam int unsigned MARK_LO = 16;
    localparam int unsigned MARK_HI = CELL - 1 - MARK_LO;
    localparam int unsigned CENTRE  = CELL / 2;
    localparam int unsigned R2_MIN  = 900;
    localparam int unsigned R2_MAX  = 1600;
    localparam int unsigned CNT_W   = 24;

    state_t                state, state_nx;
    logic [BOARD_BITS-1:0] board, board_nx;
    logic [1:0]            crow, crow_nx, ccol, ccol_nx;
    logic                  turn_nx;
    logic [1:0]            winner_nx;
    logic [3:0]            cur_idx;
    logic [1:0]            mover;
    logic                  win_c, full_c;
    logic [2:0]            win_line_c;

    assign cur_idx = 4'(crow) * 4'd3 + 4'(ccol);
    assign mover   = turn ? CELL_X : CELL_O;

    ttt_win_check u_win_check (
        .board  (board),
        .player (mover),
        .win_c  (win_c),
        .line_c (win_line_c),
        .full_c (full_c)
    );

    always_ff @(posedge clk_25mhz or posedge clr) begin
        if (clr) begin
            state     <= PLAY;
            board     <= '0;
            crow      <= 2'd1;
            ccol      <= 2'd1;
            turn      <= 1'b0;
            winner    <= WIN_NONE;
            game_over <= 1'b0;
        end else begin
            state     <= state_nx;
            board     <= board_nx;
            crow      <= crow_nx;
            ccol      <= ccol_nx;
            turn      <= turn_nx;
            winner    <= winner_nx;
            game_over <= (state_nx == OVER);
        end
    end

    // Game FSM; place reads the pre-move cursor, moves still apply in the same cycle.
    always_comb begin
        state_nx  = state;
        board_nx  = board;
        crow_nx   = crow;
        ccol_nx   = ccol;
        turn_nx   = turn;
        winner_nx = winner;
        if (new_game) begin
            state_nx  = PLAY;
            board_nx  = '0;
            crow_nx   = 2'd1;
            ccol_nx   = 2'd1;
            turn_nx   = 1'b0;
            winner_nx = WIN_NONE;
        end else begin
            case (state)
                PLAY: begin
                    if (place && cell_at(board, cur_idx) == CELL_EMPTY) begin
                        board_nx[{cur_idx, 1'b0} +: 2] = turn ? CELL_O : CELL_X;
                        turn_nx  = ~turn;
                        state_nx = CHECK;
                    end
                    if (mv_up && !mv_down && crow != 2'd0)    crow_nx = crow - 2'd1;
                    if (mv_down && !mv_up && crow != 2'd2)    crow_nx = crow + 2'd1;
                    if (mv_left && !mv_right && ccol != 2'd0) ccol_nx = ccol - 2'd1;
                    if (mv_right && !mv_left && ccol != 2'd2) ccol_nx = ccol + 2'd1;
                end
                CHECK: begin
                    if (win_c) begin
                        winner_nx = (mover == CELL_X) ? WIN_X : WIN_O;
                        state_nx  = OVER;
                    end else if (full_c) begin
                        winner_nx = WIN_DRAW;
                        state_nx  = OVER;
                    end else begin
                        state_nx  = PLAY;
                    end
                end
                OVER:    state_nx = OVER;
                default: state_nx = PLAY;
            endcase
        end
    end

    logic blank_c;
`ifdef TTT_WIN_BLINK_EN
    logic [CNT_W-1:0] blink_cnt;
    logic [2:0]       win_line_q;
    logic [11:0]      win_trip;
    logic [3:0]       pix_idx_b;

    always_ff @(posedge clk_25mhz or posedge clr) begin
        if (clr) begin
            blink_cnt  <= '0;
            win_line_q <= 3'd0;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
            if (state == CHECK && win_c) win_line_q <= win_line_c;
        end
    end

    assign win_trip = win_line(win_line_q);
`else
    logic unused_line;
    assign unused_line = ^win_line_c;
`endif

    function automatic logic [8:0] split(input logic [PIX_W-1:0] r);
        if (r < PIX_W'(CELL))          return {2'd0, OFS_W'(r)};
        else if (r < PIX_W'(2 * CELL)) return {2'd1, OFS_W'(r - PIX_W'(CELL))};
        else                           return {2'd2, OFS_W'(r - PIX_W'(2 * CELL))};
    endfunction

    logic             in_board, grid, cursor, x_mark, o_mark;
    logic [PIX_W-1:0] rel_x, rel_y;
    logic [1:0]       col, row;
    logic [OFS_W-1:0] dx, dy, ad, ox, oy;
    logic [7:0]       sum, as;
    logic [13:0]      sqx, sqy;
    logic [14:0]      r2;
    logic [3:0]       pix_idx;
    logic [1:0]       pix_cell;
    logic [2:0]       rgb_nx;

    // Pixel colour: locate cell and offsets, then apply grid > cursor > X > O priority.
    always_comb begin
        rel_x    = pixel_x - PIX_W'(BOARD_X0);
        rel_y    = pixel_y - PIX_W'(BOARD_Y0);
        in_board = vga_on &&
                   pixel_x >= PIX_W'(BOARD_X0) && pixel_x < PIX_W'(BOARD_X0 + 3 * CELL) &&
                   pixel_y >= PIX_W'(BOARD_Y0) && pixel_y < PIX_W'(BOARD_Y0 + 3 * CELL);
        {col, dx} = split(rel_x);
        {row, dy} = split(rel_y);
        pix_idx   = 4'(row) * 4'd3 + 4'(col);
        pix_cell  = cell_at(board, pix_idx);

        grid   = dx < OFS_W'(LINE_W) || dy < OFS_W'(LINE_W) ||
                 (col == 2'd2 && dx >= OFS_W'(CELL - LINE_W)) ||
                 (row == 2'd2 && dy >= OFS_W'(CELL - LINE_W));
        cursor = row == crow && col == ccol &&
                 ((dx >= OFS_W'(LINE_W) && dx < OFS_W'(2 * LINE_W)) ||
                  (dy >= OFS_W'(LINE_W) && dy < OFS_W'(2 * LINE_W)));

        ad  = (dx >= dy) ? dx - dy : dy - dx;
        sum = {1'b0, dx} + {1'b0, dy};
        as  = (sum >= 8'(CELL - 1)) ? sum - 8'(CELL - 1) : 8'(CELL - 1) - sum;
        x_mark = pix_cell == CELL_X &&
                 dx >= OFS_W'(MARK_LO) && dx <= OFS_W'(MARK_HI) &&
                 dy >= OFS_W'(MARK_LO) && dy <= OFS_W'(MARK_HI) &&
                 (ad < OFS_W'(LINE_W) || as < 8'(LINE_W));

        ox  = (dx >= OFS_W'(CENTRE)) ? dx - OFS_W'(CENTRE) : OFS_W'(CENTRE) - dx;
        oy  = (dy >= OFS_W'(CENTRE)) ? dy - OFS_W'(CENTRE) : OFS_W'(CENTRE) - dy;
        sqx = {7'd0, ox} * {7'd0, ox};
        sqy = {7'd0, oy} * {7'd0, oy};
        r2  = {1'b0, sqx} + {1'b0, sqy};
        o_mark = pix_cell == CELL_O && r2 >= 15'(R2_MIN) && r2 <= 15'(R2_MAX);

`ifdef TTT_WIN_BLINK_EN
        pix_idx_b = pix_idx;
        blank_c   = (winner == WIN_X || winner == WIN_O) && blink_cnt[CNT_W-1] &&
                    (pix_idx_b == win_trip[11:8] || pix_idx_b == win_trip[7:4] ||
                     pix_idx_b == win_trip[3:0]);
`else
        blank_c   = 1'b0;
`endif

        rgb_nx = 3'b000;
        if (in_board) begin
            if (grid)                     rgb_nx = 3'b111;
            else if (cursor)              rgb_nx = game_over ? 3'b101 : 3'b010;
            else if (x_mark && !blank_c)  rgb_nx = 3'b100;
            else if (o_mark && !blank_c)  rgb_nx = 3'b001;
        end
    end

    always_ff @(posedge clk_25mhz or posedge clr) begin
        if (clr) {ttt_r, ttt_g, ttt_b} <= 3'b000;
        else     {ttt_r, ttt_g, ttt_b} <= rgb_nx;
    end

endmodule

// File: tb/tb_ttt_pixel_gen.sv
// Self-checking bench for ttt_pixel_gen: pixel vector table, scoreboarded probes, game sequences.
module tb_ttt_pixel_gen;

    logic        clk_25mhz = 1'b0;
    logic        clr = 1'b1;
    logic [10:0] pixel_x = '0, pixel_y = '0;
    logic        vga_on = 1'b0;
    logic        mv_up = 0, mv_down = 0, mv_left = 0, mv_right = 0, place = 0, new_game = 0;
    logic        ttt_r, ttt_g, ttt_b, turn, game_over;
    logic [1:0]  winner;

    ttt_pixel_gen dut (
        .clk_25mhz (clk_25mhz), .clr (clr),
        .pixel_x (pixel_x), .pixel_y (pixel_y), .vga_on (vga_on),
        .mv_up (mv_up), .mv_down (mv_down), .mv_left (mv_left), .mv_right (mv_right),
        .place (place), .new_game (new_game),
        .ttt_r (ttt_r), .ttt_g (ttt_g), .ttt_b (ttt_b),
        .turn (turn), .winner (winner), .game_over (game_over)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    localparam logic [5:0] B_UP = 6'd1, B_DN = 6'd2, B_LT = 6'd4, B_RT = 6'd8,
                           B_PL = 6'd16, B_NG = 6'd32;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        on;
        logic [2:0]  rgb;
    } vec_t;

    vec_t       vecs[11];
    logic [2:0] sb_q[$];
    int         n_pass = 0, n_total = 0;
    int         cr = 1, cc = 1;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic probe(input logic [10:0] x, input logic [10:0] y, input logic on,
                         input logic [2:0] exp, input string nm);
        logic [2:0] e;
        pixel_x = x; pixel_y = y; vga_on = on;
        sb_q.push_back(exp);
        @(posedge clk_25mhz); #1;
        e = sb_q.pop_front();
        check(nm, {1'b0, ttt_r, ttt_g, ttt_b}, {1'b0, e});
    endtask

    task automatic btn(input logic [5:0] b);
        {new_game, place, mv_right, mv_left, mv_down, mv_up} = b;
        @(posedge clk_25mhz); #1;
        {new_game, place, mv_right, mv_left, mv_down, mv_up} = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_25mhz); #1; end
    endtask

    task automatic place_at(input int r, input int c);
        while (cr < r) begin btn(B_DN); cr++; end
        while (cr > r) begin btn(B_UP); cr--; end
        while (cc < c) begin btn(B_RT); cc++; end
        while (cc > c) begin btn(B_LT); cc--; end
        btn(B_PL);
        idle(1);
    endtask

    task automatic check_status(input string nm, input logic t, input logic [1:0] w, input logic g);
        check({nm, ".turn"}, {3'd0, turn}, {3'd0, t});
        check({nm, ".winner"}, {2'd0, winner}, {2'd0, w});
        check({nm, ".game_over"}, {3'd0, game_over}, {3'd0, g});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{11'd200, 11'd120, 1'b1, 3'b000};
        vecs[1]  = '{11'd140, 11'd60,  1'b1, 3'b111};
        vecs[2]  = '{11'd265, 11'd185, 1'b1, 3'b010};
        vecs[3]  = '{11'd139, 11'd60,  1'b1, 3'b000};
        vecs[4]  = '{11'd500, 11'd420, 1'b1, 3'b000};
        vecs[5]  = '{11'd499, 11'd419, 1'b1, 3'b111};
        vecs[6]  = '{11'd140, 11'd60,  1'b0, 3'b000};
        vecs[7]  = '{11'd260, 11'd180, 1'b1, 3'b111};
        vecs[8]  = '{11'd262, 11'd190, 1'b1, 3'b111};
        vecs[9]  = '{11'd300, 11'd186, 1'b1, 3'b010};
        vecs[10] = '{11'd320, 11'd240, 1'b1, 3'b000};

        // Reset state
        pixel_x = 11'd140; pixel_y = 11'd60; vga_on = 1'b1;
        repeat (2) @(posedge clk_25mhz);
        #1;
        check("reset.rgb", {1'b0, ttt_r, ttt_g, ttt_b}, 4'h0);
        check_status("reset", 1'b0, 2'b00, 1'b0);
        clr = 1'b0;
        idle(1);

        for (int i = 0; i < 11; i++)
            probe(vecs[i].x, vecs[i].y, vecs[i].on, vecs[i].rgb, $sformatf("pix[%0d]", i));

        // X at centre, then a second place on the occupied cell
        btn(B_PL);
        check("place1.turn", {3'd0, turn}, 4'd1);
        idle(1);
        probe(11'd320, 11'd240, 1'b1, 3'b100, "x_centre");
        btn(B_PL);
        idle(2);
        check_status("occupied", 1'b1, 2'b00, 1'b0);
        probe(11'd320, 11'd240, 1'b1, 3'b100, "x_centre_kept");

        btn(B_NG);
        check_status("ng1", 1'b0, 2'b00, 1'b0);
        probe(11'd320, 11'd240, 1'b1, 3'b000, "ng1.cleared");

        // X wins top row; moves combined with place use the pre-move cursor
        btn(B_UP | B_LT);
        btn(B_PL | B_DN);      idle(1);
        btn(B_PL | B_UP | B_RT); idle(1);
        btn(B_PL | B_DN);      idle(1);
        btn(B_PL | B_UP | B_RT); idle(1);
        btn(B_PL);
        check_status("win.check_cycle", 1'b1, 2'b00, 1'b0);
        idle(1);
        check_status("win", 1'b1, 2'b01, 1'b1);
        cr = 0; cc = 2;
        probe(11'd200, 11'd120, 1'b1, 3'b100, "win.x_cell0");
        probe(11'd320, 11'd120, 1'b1, 3'b100, "win.x_cell1");
        probe(11'd200, 11'd275, 1'b1, 3'b001, "win.o_cell3");
        probe(11'd320, 11'd275, 1'b1, 3'b001, "win.o_cell4");
        probe(11'd385, 11'd110, 1'b1, 3'b101, "win.cursor_magenta");

        // OVER ignores moves and place
        btn(B_DN);
        btn(B_PL | B_LT);
        idle(1);
        check_status("over_ignore", 1'b1, 2'b01, 1'b1);
        probe(11'd385, 11'd110, 1'b1, 3'b101, "over.cursor_still");
        probe(11'd385, 11'd230, 1'b1, 3'b000, "over.no_mark");

        btn(B_NG);
        cr = 1; cc = 1;
        check_status("ng_over", 1'b0, 2'b00, 1'b0);
        probe(11'd200, 11'd120, 1'b1, 3'b000, "ng_over.cleared");
        probe(11'd265, 11'd185, 1'b1, 3'b010, "ng_over.cursor");

        // Draw: X 0,2,3,7,8  O 1,4,5,6
        place_at(0, 0); place_at(0, 1); place_at(0, 2); place_at(1, 1); place_at(1, 0);
        place_at(1, 2); place_at(2, 1); place_at(2, 0); place_at(2, 2);
        check_status("draw", 1'b1, 2'b11, 1'b1);
        probe(11'd385, 11'd350, 1'b1, 3'b101, "draw.cursor_magenta");
        probe(11'd440, 11'd360, 1'b1, 3'b100, "draw.x_cell8");

        // Cursor saturation and conflicting moves
        btn(B_NG);
        repeat (5) btn(B_LT);
        probe(11'd145, 11'd185, 1'b1, 3'b010, "sat.left");
        probe(11'd265, 11'd185, 1'b1, 3'b000, "sat.old_cell");
        btn(B_UP | B_DN);
        probe(11'd145, 11'd185, 1'b1, 3'b010, "updown.same_row");
        repeat (3) btn(B_UP);
        probe(11'd145, 11'd65, 1'b1, 3'b010, "sat.up");
        probe(11'd145, 11'd185, 1'b1, 3'b000, "sat.up_old");
        btn(B_LT | B_RT);
        probe(11'd145, 11'd65, 1'b1, 3'b010, "leftright.same_col");

        // Asynchronous clr during CHECK
        btn(B_NG);
        cr = 1; cc = 1;
        pixel_x = 11'd140; pixel_y = 11'd60; vga_on = 1'b1;
        btn(B_PL);
        check("clr.pre_rgb", {1'b0, ttt_r, ttt_g, ttt_b}, 4'h7);
        check("clr.pre_turn", {3'd0, turn}, 4'd1);
        #5 clr = 1'b1;
        #1;
        check("clr.async_rgb", {1'b0, ttt_r, ttt_g, ttt_b}, 4'h0);
        check_status("clr.async", 1'b0, 2'b00, 1'b0);
        @(posedge clk_25mhz); #5;
        clr = 1'b0;
        @(posedge clk_25mhz); #1;
        probe(11'd320, 11'd240, 1'b1, 3'b000, "clr.board_empty");
        btn(B_PL);
        check("clr.play_turn", {3'd0, turn}, 4'd1);
        idle(1);
        probe(11'd320, 11'd240, 1'b1, 3'b100, "clr.play_mark");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ttt_pixel_gen.md
Name: ttt_pixel_gen

Overview:
Tic-tac-toe game core and pixel generator; sits directly upstream of vga_controller, replacing its fixed switch colours with the ttt_r/g/b stream.
- Holds 3x3 board state, cursor, turn and win/draw FSM; driven by one-shot button pulses.
- Each cycle maps the pixel coordinate from vga_timer to a registered RGB colour.

Parameters:
BOARD_X0, 140, left pixel column of board
BOARD_Y0, 60, top pixel row of board
CELL, 120, cell edge in pixels (board = 3*CELL square)
LINE_W, 4, grid/cursor/mark stroke width in pixels

Ports:
clk_25mhz  in  1  pixel clock
clr  in  1  reset
pixel_x  in  11  current column from vga_timer
pixel_y  in  11  current row from vga_timer
vga_on  in  1  visible-area flag
mv_up, mv_down, mv_left, mv_right  in  1 each  single-cycle cursor pulses
place  in  1  single-cycle pulse: place current player's mark at cursor
new_game  in  1  single-cycle pulse: restart game
ttt_r, ttt_g, ttt_b  out  1 each  registered pixel colour
turn  out  1  0 = X to move, 1 = O to move
winner  out  2  00 none, 01 X, 10 O, 11 draw
game_over  out  1  high in OVER state

Behaviour:
- Reset clr is asynchronous and active-high; clock is clk_25mhz. On reset: board all empty, cursor (row 1, col 1), turn=0, state PLAY, winner=00, game_over=0, ttt_r/g/b=0.
- Cell encoding: 2 bits; 00 empty, 01 X, 10 O. Index = row*3+col.
- FSM states:
  - PLAY: place on empty cell writes mark, toggles turn, goes to CHECK. place on occupied cell is ignored (no toggle).
  - CHECK: one cycle; evaluates the 8 lines. A line owned by the last mover sets winner to that player and enters OVER. If all 9 cells are full with no win, winner=11 and enters OVER. Otherwise returns to PLAY.
  - OVER: place and move pulses are ignored.
- All pulses arriving during CHECK are dropped.
- new_game has top priority in any state: next cycle, board empty, turn=0, cursor (1,1), winner=00, state PLAY.
- Cursor:
  - Saturates at 0 and 2 (no wrap).
  - mv_up and mv_down together means no vertical change; mv_left and mv_right together means no horizontal change.
  - A move and place in the same cycle: place uses the pre-move cursor and the move still applies.
- Pixel path, 1-cycle latency (ttt_* valid the cycle after pixel_x/y):
  - Outside vga_on: black.
  - Outside the board: black.
  - Compute col/row by threshold compare and in-cell offsets dx, dy (0..CELL-1).
  - Colour priority:
    1. Grid line (offset < LINE_W at internal cell boundaries, or outer border): white.
    2. Cursor outline (offset in [LINE_W, 2*LINE_W) within cursor cell): green; magenta (r+b) when game_over.
    3. X mark (dx, dy in [16,103] and |dx-dy| < LINE_W or |dx+dy-(CELL-1)| < LINE_W): red.
    4. O mark (r² = (dx-60)²+(dy-60)², 900 <= r² <= 1600): blue.
    5. Otherwise black.
  - Squares are 7x7-bit unsigned multiplies, 14-bit result.
- Board writes take effect on pixel output one cycle after the write; no frame synchronisation is applied.

Optional Feature:
TTT_WIN_BLINK_EN
- Defined: adds a 24-bit free-running counter. While winner is 01 or 10, marks in the three winning cells are blanked to black whenever counter[23]=1 (~1.5 Hz). The winning-line index (0-7) is latched in CHECK.
- Undefined: no counter and no latch; winning marks are drawn steadily.

Decomposition:
- ttt_pkg holds:
  - cell encoding constants
  - winner codes
  - FSM state enum (PLAY, CHECK, OVER)
  - geometry defaults
  - the 8 win-line index triples {0,1,2},{3,4,5},{6,7,8},{0,3,6},{1,4,7},{2,5,8},{0,4,8},{2,4,6}
- Sub-module ttt_win_check: combinational; takes the board (18 bits) and player; returns win flag, line index and full flag. It is instantiated once and used in CHECK.

Test Plan:
- Reset, then pixel (200,120) with vga_on=1 → next cycle rgb=000. Pixel (140,60) → 111 (border). Cursor cell (1,1) outline at (265,185) → 010.
- place at (1,1), then probe (320,240) (centre of an X diagonal, dx=dy=60) → rgb=100, turn=1. A second place at (1,1) → turn stays 1, cell unchanged.
- X at cells 0,1,2 with O at 3,4 via moves and place → two cycles after the final place, winner=01 and game_over=1; further place is ignored.
- Fill the board with no line (X:0,2,3,7,8; O:1,4,5,6) → winner=11 and cursor outline magenta.
- mv_left×5 from reset → cursor col=0; mv_up+mv_down in the same cycle → row unchanged; new_game while in OVER → board empty, winner=00, turn=0.
- clr asserted mid-CHECK → outputs reset immediately (asynchronous); state PLAY on release.
